// File: rtl/tx_escape.sv
// Transmit-side escaper: command bytes get an ESC prefix, data bytes equal to ESC are doubled.
// Optional macro TX_ESCAPE_CNT_EN adds ESC_CNT_O, a saturating count of inserted ESC bytes.
module tx_escape #(
  parameter logic [7:0] ESC = 8'hB1
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] DATA_SEND_I,
  input  logic       COMMAND_I,
  input  logic       WRITE_I,
  output logic       TX_READY_O,
  output logic [7:0] DATA_SEND_O,
  output logic       WRITE_O,
  input  logic       TX_READY_I,
  output logic       CMD_ERR_O
`ifdef TX_ESCAPE_CNT_EN
  ,
  output logic [15:0] ESC_CNT_O
`endif
);

  // Handshakes: TAP byte moves when WRITE_I && TX_READY_O at a rising edge;
  // UART byte moves in every cycle WRITE_O is high (WRITE_O already implies TX_READY_I).
  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_escape = 2'd1,
    st_data   = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] data_q;
  logic       cmd_err_q;
  logic       accept;
  logic       illegal_cmd;

  assign accept      = TX_READY_O && WRITE_I;
  assign illegal_cmd = accept && COMMAND_I && (DATA_SEND_I == ESC);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= st_idle;
      data_q    <= 8'h00;
      cmd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) data_q <= DATA_SEND_I;
      if (illegal_cmd) cmd_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    TX_READY_O  = 1'b0;
    WRITE_O     = 1'b0;
    DATA_SEND_O = data_q;
    case (state_q)
      st_idle: begin
        TX_READY_O = 1'b1;
        if (WRITE_I) begin
          // An ESC command byte cannot be encoded; it is flagged and dropped.
          if (COMMAND_I && (DATA_SEND_I == ESC)) state_d = st_idle;
          else if (COMMAND_I || (DATA_SEND_I == ESC)) state_d = st_escape;
          else state_d = st_data;
        end
      end
      st_escape: begin
        DATA_SEND_O = ESC;
        if (TX_READY_I) begin
          WRITE_O = 1'b1;
          state_d = st_data;
        end
      end
      st_data: begin
        if (TX_READY_I) begin
          WRITE_O = 1'b1;
          state_d = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  assign CMD_ERR_O = cmd_err_q;

`ifdef TX_ESCAPE_CNT_EN
  logic [15:0] esc_cnt_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) esc_cnt_q <= 16'h0000;
    else if ((state_q == st_escape) && TX_READY_I && (esc_cnt_q != 16'hFFFF))
      esc_cnt_q <= esc_cnt_q + 16'h0001;
  end

  assign ESC_CNT_O = esc_cnt_q;
`endif

endmodule

// File: doc/tx_escape.md
Name: tx_escape

Overview:
- Transmit-side counterpart of the UART debug link's RX escape decoder. Sits between the TAP and the UART-TX.
- Takes one byte per handshake from the TAP, tagged as data or command, and emits the escaped byte stream to UART-TX.
- Command bytes are preceded by ESC. Data bytes equal to ESC are doubled (ESC ESC), so the receiver's escape decoder recovers the original stream.

Parameters:
ESC, 8'hB1, escape symbol; must match the receiver's ESC.

Ports:
CLK_I  input  1  system clock
RST_I  input  1  reset, asynchronous, active-high
DATA_SEND_I  input  8  byte from TAP
COMMAND_I  input  1  1 = DATA_SEND_I is a command byte, 0 = data byte; sampled with WRITE_I
WRITE_I  input  1  TAP write strobe; accepted when TX_READY_O = 1
TX_READY_O  output  1  block can accept a byte from TAP
DATA_SEND_O  output  8  byte to UART-TX
WRITE_O  output  1  one-cycle write strobe to UART-TX
TX_READY_I  input  1  UART-TX can accept a byte this cycle
CMD_ERR_O  output  1  sticky flag: TAP wrote a command byte equal to ESC

Behaviour:
- Reset (async assert, sync deassert to CLK_I):
  - state = st_idle, data register = 8'h00, CMD_ERR_O = 0.
  - Resulting outputs: TX_READY_O = 1, WRITE_O = 0, DATA_SEND_O = 8'h00.
- Registers: state, data (8 bit), cmd_err. Outputs are combinational from state, data and TX_READY_I.
- TX_READY_O = 1 only in st_idle.
- TAP handshake: a transfer occurs when WRITE_I = 1 and TX_READY_O = 1 at a rising edge. WRITE_I while not ready is ignored; the TAP holds it.
- UART handshake: WRITE_O = 1 only in st_escape or st_data, and only while TX_READY_I = 1. Each WRITE_O cycle transfers exactly one byte.
- States:
  - st_idle: DATA_SEND_O = data. On WRITE_I, latch DATA_SEND_I into data, then branch:
    - COMMAND_I = 1 and DATA_SEND_I == ESC: illegal. Set cmd_err, send nothing, stay in st_idle.
    - COMMAND_I = 1 otherwise: go to st_escape.
    - COMMAND_I = 0 and DATA_SEND_I == ESC: go to st_escape (byte stuffing).
    - Else: go to st_data.
  - st_escape: DATA_SEND_O = ESC. If TX_READY_I: WRITE_O = 1, go to st_data. Else hold.
  - st_data: DATA_SEND_O = data. If TX_READY_I: WRITE_O = 1, go to st_idle. Else hold.
  - Any illegal state encoding: go to st_idle.
- Latency, with TX_READY_I held at 1:
  - TAP write accepted at edge n; first WRITE_O in cycle n+1.
  - Plain data byte: 1 UART write; TX_READY_O returns at n+2.
  - Command byte or ESC data byte: 2 UART writes in cycles n+1 and n+2; TX_READY_O returns at n+3.
- Backpressure: TX_READY_I low stalls indefinitely. DATA_SEND_O is stable while stalled; data does not change until the next acceptance.
- No pipelining: WRITE_I in the same cycle as the final WRITE_O is not accepted (TX_READY_O = 0 that cycle).
- Ordering: bytes leave in TAP acceptance order. The ESC prefix and its following byte are never separated by another byte.
- CMD_ERR_O: stays 1 until reset. Does not block further traffic.
- Reset mid-sequence (e.g. in st_data after ESC was sent): state returns to st_idle immediately, the pending byte is lost, WRITE_O drops asynchronously. The receiver resynchronises on the next byte.

Optional Feature:
- Macro: TX_ESCAPE_CNT_EN.
- Defined:
  - Adds output port ESC_CNT_O, 16 bits: count of inserted ESC bytes, i.e. WRITE_O cycles in st_escape.
  - Saturates at 16'hFFFF. Reset to 0.
  - Increments on the same edge as the st_escape write.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Plain data: reset, write data 8'h41 with TX_READY_I = 1. Expect WRITE_O one cycle later with DATA_SEND_O = 8'h41, exactly one UART write, TX_READY_O back to 1 two cycles after acceptance.
- Command: write 8'h05 with COMMAND_I = 1. Expect UART sequence B1, 05 in consecutive cycles.
- ESC as data: write data 8'hB1. Expect UART sequence B1, B1. Feeding the output into the RX escape decoder yields one data byte B1 with COMMAND_O = 0.
- Backpressure: write command 8'h07 with TX_READY_I = 0 for 5 cycles, then 1 for 1 cycle, then 0 for 3 cycles, then 1. Expect DATA_SEND_O = B1 held through the first stall; a write of B1; 07 held through the second stall; then a write of 07. Exactly 2 WRITE_O pulses; TX_READY_O = 0 throughout.
- Illegal command: write 8'hB1 with COMMAND_I = 1. Expect no WRITE_O, CMD_ERR_O = 1 from the next cycle and held. A following data write 8'h10 is still sent normally.
- Reset and counter: assert RST_I while in st_data. Expect WRITE_O = 0 and TX_READY_O = 1 immediately, DATA_SEND_O = 00. With TX_ESCAPE_CNT_EN: after 3 command writes and 2 ESC-data writes, ESC_CNT_O = 5; after reset, 0.
